// File: rtl/pong_pkg.sv
// Shared definitions for the animated pong playfield.
// Holds default geometry and speed constants, the 4-bit colour codes and
// the direction encoding used for the ball's x and y motion.
package pong_pkg;

    localparam int unsigned DEF_MAX_X      = 640;
    localparam int unsigned DEF_MAX_Y      = 480;
    localparam int unsigned DEF_WALL_X_L   = 32;
    localparam int unsigned DEF_WALL_X_R   = 35;
    localparam int unsigned DEF_BAR_X_L    = 600;
    localparam int unsigned DEF_BAR_X_R    = 603;
    localparam int unsigned DEF_BAR_Y_SIZE = 72;
    localparam int unsigned DEF_BAR_V      = 4;
    localparam int unsigned DEF_BALL_SIZE  = 8;
    localparam int unsigned DEF_BALL_V     = 2;
    localparam int unsigned DEF_CNT_W      = 8;

    localparam logic [3:0] WALL_RGB = 4'ha;
    localparam logic [3:0] BAR_RGB  = 4'h3;
    localparam logic [3:0] BALL_RGB = 4'h9;
    localparam logic [3:0] BG_RGB   = 4'he;

    // DIR_POS: right / down, DIR_NEG: left / up
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

endpackage

// File: rtl/pong_ball_ctrl.sv
// Ball motion and collision resolution, advanced once per frame tick.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   tick                one-clock frame update strobe
//   bar_y               current bar top edge
//   ball_x, ball_y      ball top-left corner
//   hit, miss           one-clock event pulses, the clock after the tick
//   hit_cnt, miss_cnt   wrapping event counters
module pong_ball_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned MAX_X      = DEF_MAX_X,
    parameter int unsigned MAX_Y      = DEF_MAX_Y,
    parameter int unsigned WALL_X_R   = DEF_WALL_X_R,
    parameter int unsigned BAR_X_L    = DEF_BAR_X_L,
    parameter int unsigned BAR_X_R    = DEF_BAR_X_R,
    parameter int unsigned BAR_Y_SIZE = DEF_BAR_Y_SIZE,
    parameter int unsigned BALL_SIZE  = DEF_BALL_SIZE,
    parameter int unsigned BALL_V     = DEF_BALL_V,
    parameter int unsigned CNT_W      = DEF_CNT_W
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [15:0]      bar_y,
    output logic [15:0]      ball_x,
    output logic [15:0]      ball_y,
    output logic             hit,
    output logic             miss,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [15:0] X_START  = 16'(MAX_X / 2);
    localparam logic [15:0] Y_START  = 16'(MAX_Y / 2);
    localparam logic [15:0] Y_LIM    = 16'(MAX_Y);
    localparam logic [15:0] STEP     = 16'(BALL_V);
    localparam logic [15:0] SIZE     = 16'(BALL_SIZE);
    localparam logic [15:0] WALL_LIM = 16'(WALL_X_R + 1 + BALL_V);
    localparam logic [15:0] MISS_LIM = 16'(MAX_X - BALL_SIZE);
    localparam logic [15:0] BAR_L    = 16'(BAR_X_L);
    localparam logic [15:0] BAR_R    = 16'(BAR_X_R);
    localparam logic [15:0] BAR_H    = 16'(BAR_Y_SIZE);

    dir_t        dir_x, dir_y, dir_x_n, dir_y_n;
    logic [15:0] x_n, y_n, ball_r;
    logic        hit_c, miss_c;

    always_comb begin
        dir_x_n = dir_x;
        dir_y_n = dir_y;
        hit_c   = 1'b0;
        ball_r  = ball_x + SIZE - 16'd1;
        miss_c  = (ball_x >= MISS_LIM);

        if (ball_y <= STEP)
            dir_y_n = DIR_POS;
        else if (ball_y + SIZE + STEP >= Y_LIM)
            dir_y_n = DIR_NEG;

        if (ball_x <= WALL_LIM)
            dir_x_n = DIR_POS;

        if ((dir_x == DIR_POS) && (ball_r >= BAR_L) && (ball_r <= BAR_R) &&
            (ball_y <= bar_y + BAR_H - 16'd1) && (ball_y + SIZE - 16'd1 >= bar_y)) begin
            dir_x_n = DIR_NEG;
            hit_c   = 1'b1;
        end

        // step uses the direction just resolved, so a bounce moves away in the same tick
        x_n = (dir_x_n == DIR_POS) ? ball_x + STEP : ball_x - STEP;
        y_n = (dir_y_n == DIR_POS) ? ball_y + STEP : ball_y - STEP;

        // a miss discards every other update this tick and serves from the centre
        if (miss_c) begin
            x_n     = X_START;
            y_n     = Y_START;
            dir_x_n = DIR_NEG;
            dir_y_n = dir_y;
            hit_c   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ball_x   <= X_START;
            ball_y   <= Y_START;
            dir_x    <= DIR_POS;
            dir_y    <= DIR_POS;
            hit      <= 1'b0;
            miss     <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            hit  <= tick && hit_c;
            miss <= tick && miss_c;
            if (tick) begin
                ball_x <= x_n;
                ball_y <= y_n;
                dir_x  <= dir_x_n;
                dir_y  <= dir_y_n;
                if (hit_c)
                    hit_cnt <= hit_cnt + 1'b1;
                if (miss_c)
                    miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pong_anim_display.sv
// Animated pong playfield: wall, player bar and moving ball.
// Sits between the VGA sync generator and the RGB output mux.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   video_on            visible-region flag from the sync generator
//   pix_x, pix_y        current pixel column / row
//   btn_up, btn_dn      synchronised bar controls (level)
//   pause               freezes all motion; rendering continues
//   graph_rgb           registered pixel colour (one clock latency)
//   hit, miss           one-clock pulses after a frame with that event
//   hit_cnt, miss_cnt   wrapping event counters
module pong_anim_display
    import pong_pkg::*;
#(
    parameter int unsigned MAX_X      = DEF_MAX_X,
    parameter int unsigned MAX_Y      = DEF_MAX_Y,
    parameter int unsigned WALL_X_L   = DEF_WALL_X_L,
    parameter int unsigned WALL_X_R   = DEF_WALL_X_R,
    parameter int unsigned BAR_X_L    = DEF_BAR_X_L,
    parameter int unsigned BAR_X_R    = DEF_BAR_X_R,
    parameter int unsigned BAR_Y_SIZE = DEF_BAR_Y_SIZE,
    parameter int unsigned BAR_V      = DEF_BAR_V,
    parameter int unsigned BALL_SIZE  = DEF_BALL_SIZE,
    parameter int unsigned BALL_V     = DEF_BALL_V,
    parameter int unsigned CNT_W      = DEF_CNT_W
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             video_on,
    input  logic [15:0]      pix_x,
    input  logic [15:0]      pix_y,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             pause,
    output logic [3:0]       graph_rgb,
    output logic             hit,
    output logic             miss,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [15:0] TICK_Y    = 16'(MAX_Y);
    localparam logic [15:0] BAR_Y_RST = 16'(MAX_Y / 2 - BAR_Y_SIZE / 2);
    localparam logic [15:0] BAR_Y_MAX = 16'(MAX_Y - BAR_Y_SIZE);
    localparam logic [15:0] BAR_STEP  = 16'(BAR_V);
    localparam logic [15:0] BAR_H     = 16'(BAR_Y_SIZE);
    localparam logic [15:0] WALL_L    = 16'(WALL_X_L);
    localparam logic [15:0] WALL_R    = 16'(WALL_X_R);
    localparam logic [15:0] BAR_L     = 16'(BAR_X_L);
    localparam logic [15:0] BAR_R     = 16'(BAR_X_R);
    localparam logic [15:0] BALL_SZ   = 16'(BALL_SIZE);

    logic        cond, cond_d, refr_tick;
    logic [15:0] bar_y, bar_n;
    logic [15:0] ball_x, ball_y;
    logic        wall_on, bar_on, ball_on;
    logic [3:0]  rgb_n;

    // edge-detect so a pixel position held for several clocks yields one tick;
    // the history keeps updating under pause so release never fires a stale tick
    assign cond      = (pix_y == TICK_Y) && (pix_x == '0);
    assign refr_tick = cond && !cond_d && !pause;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cond_d <= 1'b0;
        else
            cond_d <= cond;
    end

    always_comb begin
        bar_n = bar_y;
        if (btn_up && !btn_dn)
            bar_n = (bar_y >= BAR_STEP) ? bar_y - BAR_STEP : '0;
        else if (btn_dn && !btn_up)
            bar_n = (bar_y + BAR_STEP > BAR_Y_MAX) ? BAR_Y_MAX : bar_y + BAR_STEP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bar_y <= BAR_Y_RST;
        else if (refr_tick)
            bar_y <= bar_n;
    end

    pong_ball_ctrl #(
        .MAX_X      (MAX_X),
        .MAX_Y      (MAX_Y),
        .WALL_X_R   (WALL_X_R),
        .BAR_X_L    (BAR_X_L),
        .BAR_X_R    (BAR_X_R),
        .BAR_Y_SIZE (BAR_Y_SIZE),
        .BALL_SIZE  (BALL_SIZE),
        .BALL_V     (BALL_V),
        .CNT_W      (CNT_W)
    ) u_ball (
        .clk      (clk),
        .reset    (reset),
        .tick     (refr_tick),
        .bar_y    (bar_y),
        .ball_x   (ball_x),
        .ball_y   (ball_y),
        .hit      (hit),
        .miss     (miss),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always_comb begin
        wall_on = (pix_x >= WALL_L) && (pix_x <= WALL_R);
        bar_on  = (pix_x >= BAR_L) && (pix_x <= BAR_R) &&
                  (pix_y >= bar_y) && (pix_y <= bar_y + BAR_H - 16'd1);
        ball_on = (pix_x >= ball_x) && (pix_x <= ball_x + BALL_SZ - 16'd1) &&
                  (pix_y >= ball_y) && (pix_y <= ball_y + BALL_SZ - 16'd1);
        rgb_n = '0;
        if (video_on) begin
            if (wall_on)
                rgb_n = WALL_RGB;
            else if (bar_on)
                rgb_n = BAR_RGB;
            else if (ball_on)
                rgb_n = BALL_RGB;
            else
                rgb_n = BG_RGB;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            graph_rgb <= '0;
        else
            graph_rgb <= rgb_n;
    end

endmodule

// File: tb/tb_pong_anim_display.sv
// Scoreboard bench for pong_anim_display: stimulus pushes the expected
// response of each cycle it cares about; the monitor pops one entry per
// clock and compares, otherwise it requires hit/miss to stay low.
module tb_pong_anim_display;
    import pong_pkg::*;

    logic        clk;
    logic        reset;
    logic        video_on;
    logic [15:0] pix_x, pix_y;
    logic        btn_up, btn_dn, pause;
    logic [3:0]  graph_rgb;
    logic        hit, miss;
    logic [7:0]  hit_cnt, miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        chk_pos;
        logic        chk_rgb;
        logic        hit;
        logic        miss;
        logic [7:0]  hcnt;
        logic [7:0]  mcnt;
        logic [15:0] bx;
        logic [15:0] by;
        logic [15:0] bary;
        dir_t        dx;
        dir_t        dy;
        logic [3:0]  rgb;
    } exp_t;

    exp_t q[$];

    pong_anim_display dut (
        .clk       (clk),
        .reset     (reset),
        .video_on  (video_on),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .btn_up    (btn_up),
        .btn_dn    (btn_dn),
        .pause     (pause),
        .graph_rgb (graph_rgb),
        .hit       (hit),
        .miss      (miss),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, expv);
        end
    endtask

    // monitor: outputs here reflect the posedge that followed the push
    always @(negedge clk) begin
        exp_t m;
        if (q.size() > 0) begin
            m = q.pop_front();
            chk("hit", 32'(hit), 32'(m.hit));
            chk("miss", 32'(miss), 32'(m.miss));
            if (m.chk_pos) begin
                chk("ball_x", 32'(dut.u_ball.ball_x), 32'(m.bx));
                chk("ball_y", 32'(dut.u_ball.ball_y), 32'(m.by));
                chk("bar_y", 32'(dut.bar_y), 32'(m.bary));
                chk("dir_x", 32'(dut.u_ball.dir_x), 32'(m.dx));
                chk("dir_y", 32'(dut.u_ball.dir_y), 32'(m.dy));
                chk("hit_cnt", 32'(hit_cnt), 32'(m.hcnt));
                chk("miss_cnt", 32'(miss_cnt), 32'(m.mcnt));
            end
            if (m.chk_rgb)
                chk("graph_rgb", 32'(graph_rgb), 32'(m.rgb));
        end else begin
            chk("idle_pulse", 32'({hit, miss}), 32'd0);
        end
    end

    function automatic exp_t blank();
        exp_t e;
        e.chk_pos = 1'b0; e.chk_rgb = 1'b0; e.hit = 1'b0; e.miss = 1'b0;
        e.hcnt = '0; e.mcnt = '0; e.bx = '0; e.by = '0; e.bary = '0;
        e.dx = DIR_POS; e.dy = DIR_POS; e.rgb = '0;
        return e;
    endfunction

    function automatic exp_t mk(input int bx, input int by, input int bary, input dir_t dx,
                                input dir_t dy, input int hc, input int mc, input bit h, input bit m);
        exp_t e = blank();
        e.chk_pos = 1'b1;
        e.bx = 16'(bx); e.by = 16'(by); e.bary = 16'(bary);
        e.dx = dx; e.dy = dy; e.hcnt = 8'(hc); e.mcnt = 8'(mc);
        e.hit = h; e.miss = m;
        return e;
    endfunction

    function automatic exp_t rgbx(input logic [3:0] v);
        exp_t e = blank();
        e.chk_rgb = 1'b1;
        e.rgb = v;
        return e;
    endfunction

    // hand-traced trajectory checkpoints (k = frame tick number since reset)
    function automatic exp_t expect_for(input int k);
        case (k)
            1:   return mk(322, 242, 204, DIR_POS, DIR_POS, 0, 0, 0, 0);
            52:  return mk(424, 344,   0, DIR_POS, DIR_POS, 0, 0, 0, 0);
            61:  return mk(442, 362,   0, DIR_POS, DIR_POS, 0, 0, 0, 0);
            63:  return mk(446, 366,   0, DIR_POS, DIR_POS, 0, 0, 0, 0);
            116: return mk(552, 468,   0, DIR_POS, DIR_NEG, 0, 0, 0, 0);
            157: return mk(320, 240,   0, DIR_NEG, DIR_NEG, 0, 1, 0, 1);
            277: return mk( 80,   4,   0, DIR_NEG, DIR_POS, 0, 1, 0, 0);
            299: return mk( 40,  48,   0, DIR_POS, DIR_POS, 0, 1, 0, 0);
            475: return mk(392, 400, 300, DIR_POS, DIR_POS, 0, 1, 0, 0);
            511: return mk(464, 468, 300, DIR_POS, DIR_NEG, 0, 1, 0, 0);
            577: return mk(592, 336, 300, DIR_NEG, DIR_NEG, 1, 1, 1, 0);
            578: return mk(590, 334, 300, DIR_NEG, DIR_NEG, 1, 1, 0, 0);
            default: return blank();
        endcase
    endfunction

    task automatic cyc(input exp_t e, input bit push);
        if (push)
            q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic frame(input int k, input int hold, input bit push);
        pix_x    = 16'd0;
        pix_y    = 16'd480;
        video_on = 1'b0;
        btn_up   = (k >= 2 && k <= 63);
        btn_dn   = (k >= 62 && k <= 63) || (k >= 401 && k <= 475);
        cyc(expect_for(k), push);
        for (int i = 1; i < hold; i++)
            cyc(blank(), 1'b0);
        pix_y  = 16'd0;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        cyc(blank(), 1'b0);
    endtask

    task automatic pixel(input int x, input int y, input logic von, input logic [3:0] v);
        pix_x    = 16'(x);
        pix_y    = 16'(y);
        video_on = von;
        cyc(rgbx(v), 1'b1);
    endtask

    initial begin
        exp_t rst_e;
        rst_e = mk(320, 240, 204, DIR_POS, DIR_POS, 0, 0, 0, 0);
        rst_e.chk_rgb = 1'b1;
        rst_e.rgb = 4'h0;

        reset = 1'b1; video_on = 1'b0; pix_x = '0; pix_y = '0;
        btn_up = 1'b0; btn_dn = 1'b0; pause = 1'b0;
        @(negedge clk);
        #1;
        cyc(rst_e, 1'b1);
        reset = 1'b0;
        cyc(blank(), 1'b0);

        for (int k = 1; k <= 578; k++) begin
            frame(k, (k == 1) ? 4 : 1, 1'b1);
            if (k == 277) begin
                pause = 1'b1;
                repeat (3) frame(0, 2, 1'b0);
                pause = 1'b0;
                cyc(expect_for(277), 1'b1);
            end
        end

        pixel(33, 10, 1'b1, 4'ha);
        pixel(601, 310, 1'b1, 4'h3);
        pixel(593, 338, 1'b1, 4'h9);
        pixel(200, 100, 1'b1, 4'he);
        pixel(33, 10, 1'b0, 4'h0);

        // async reset mid-frame: checked before the next rising edge
        pix_x = 16'd33; pix_y = 16'd10; video_on = 1'b1;
        cyc(blank(), 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        q.push_back(rst_e);
        @(negedge clk);
        #1;
        cyc(blank(), 1'b0);
        reset = 1'b0; video_on = 1'b0; pix_x = '0; pix_y = '0;
        cyc(blank(), 1'b0);

        frame(1, 4, 1'b1);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, required 0", q.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
